quad_encoder_decoder: RTL

//   Upstream stage of the PID speed loop: decodes the motor's quadrature encoder

---
 rtl/quad_encoder_decoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder front end: 2-FF sync, per-channel run-length glitch
// filter, x4 decode into a wrapping position count, and a windowed speed
// sample with saturation.
module quad_encoder_decoder #(
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned SAMPLE_DIV = 500000,
  parameter int unsigned POS_W      = 32,
  parameter int unsigned SPD_W      = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_A,
  input  logic                    i_B,
  input  logic                    i_Clr,
  output logic signed [POS_W-1:0] o_Pos,
  output logic signed [SPD_W-1:0] o_Speed,
  output logic                    o_Speed_Valid,
  output logic                    o_Dir,
  output logic                    o_Err
);

  localparam int unsigned FC_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned WC_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned ACC_W = SPD_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {SPD_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {SPD_W{1'b0}}};
  localparam logic signed [ACC_W-1:0] SPD_MAX = {2'b00, {(SPD_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SPD_MIN = {2'b11, {(SPD_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  typedef enum logic {ST_WAIT_INIT, ST_TRACK} state_t;

  state_t                  state, state_next;
  logic [1:0]              meta, sync, filt, prev;  // bit 1 = A, bit 0 = B
  logic [FC_W-1:0]         fcnt [2];
  logic [1:0]              diff;
  logic                    load_prev, step_up, step_dn, illegal;
  logic [WC_W-1:0]         win;
  logic signed [ACC_W-1:0] acc, acc_add, step_val;
  logic signed [SPD_W-1:0] spd_sat;

  // Position of a {A,B} level pair along the forward Gray sequence 00,10,11,01.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b10:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  // Two-stage synchroniser; the only place the raw encoder pins are sampled.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {i_A, i_B};
      sync <= meta;
    end
  end

  // Accept a new level only after FILT_LEN consecutive differing samples.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      filt <= '0;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FC_W'(FILT_LEN - 1)) begin
          filt[i] <= sync[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FC_W'(1);
        end
      end
    end
  end

  // Decoder state register and previous-level register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_WAIT_INIT;
      prev  <= '0;
    end else begin
      state <= state_next;
      if (load_prev) prev <= filt;
    end
  end

  // Step decode: Gray-index distance of 1 is +1, 3 is -1, 2 is illegal.
  always_comb begin
    state_next = state;
    load_prev  = 1'b0;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    illegal    = 1'b0;
    diff       = gray_idx(filt) - gray_idx(prev);
    case (state)
      ST_WAIT_INIT: begin
        if (sync == filt) begin
          state_next = ST_TRACK;
          load_prev  = 1'b1;
        end
      end
      ST_TRACK: begin
        load_prev = 1'b1;
        case (diff)
          2'd1:    step_up = 1'b1;
          2'd3:    step_dn = 1'b1;
          2'd2:    illegal = 1'b1;
          default: ;
        endcase
      end
      default: state_next = ST_WAIT_INIT;
    endcase
  end

  // Saturating accumulator update and speed clamp to the output range.
  always_comb begin
    step_val = '0;
    if (step_up)      step_val = ACC_ONE;
    else if (step_dn) step_val = '1;
    acc_add = acc;
    if (step_up && acc != ACC_MAX)      acc_add = acc + ACC_ONE;
    else if (step_dn && acc != ACC_MIN) acc_add = acc - ACC_ONE;
    if (acc > SPD_MAX)      spd_sat = SPD_MAX[SPD_W-1:0];
    else if (acc < SPD_MIN) spd_sat = SPD_MIN[SPD_W-1:0];
    else                    spd_sat = acc[SPD_W-1:0];
  end

  // Position, direction, error and speed window; clear overrides steps and
  // the terminal count but leaves the filter/prev tracking untouched.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Pos         <= '0;
      o_Speed       <= '0;
      o_Speed_Valid <= 1'b0;
      o_Dir         <= 1'b0;
      o_Err         <= 1'b0;
      win           <= '0;
      acc           <= '0;
    end else begin
      o_Speed_Valid <= 1'b0;
      if (i_Clr) begin
        o_Pos <= '0;
        o_Err <= 1'b0;
        win   <= '0;
        acc   <= '0;
      end else begin
        if (step_up) begin
          o_Pos <= o_Pos + POS_W'(1);
          o_Dir <= 1'b1;
        end else if (step_dn) begin
          o_Pos <= o_Pos - POS_W'(1);
          o_Dir <= 1'b0;
        end
        if (illegal) o_Err <= 1'b1;
        if (win == WC_W'(SAMPLE_DIV - 1)) begin
          o_Speed       <= spd_sat;
          o_Speed_Valid <= 1'b1;
          win           <= '0;
          acc           <= step_val;
        end else begin
          win <= win + WC_W'(1);
          acc <= acc_add;
        end
      end
    end
  end

endmodule
